fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction queue between fetch and the decode format-scan stage (FormatDecoder).
//  Buffers fetched instruction words with address/PID/TID, and stamps each accepted word with a unique major ID.
//  Presents one instruction per cycle to decode, in the registered enable/data form the format scan consumes.
//  Absorbs decode stalls (stall_i) and pipeline flushes.
// PARAMETERS
//  addressWidth            64  instruction address width
//  instructionWidth        32  instruction word width (4-byte fixed)
//  PidSize                 20  process ID width
//  TidSize                 16  thread ID width
//  instructionCounterWidth 64  major ID counter width
//  queueDepth               4  entries; power of two, >=2
//  queueIndexWidth          2  log2(queueDepth)
// PORTS
//  clock_i               in   1                   clock, all state on rising edge
//  reset_i               in   1                   synchronous, active-high reset
//  fetchEnable_i         in   1                   fetch presents a valid word this cycle
//  fetchInstruction_i    in   instructionWidth    instruction word, bit 0 = MSB (opcode in [0:5])
//  fetchAddress_i        in   addressWidth        instruction address
//  fetchPid_i            in   PidSize             process ID
//  fetchTid_i            in   TidSize             thread ID
//  fetchReady_o          out  1                   queue can accept a word this cycle
//  flush_i               in   1                   discard all queued and presented instructions
//  stall_i               in   1                   decode stalled; hold outputs
//  enable_o              out  1                   output bundle valid (drives decode enable_i)
//  instruction_o         out  instructionWidth    head instruction word
//  instructionAddress_o  out  addressWidth        head address
//  instructionPid_o      out  PidSize             head PID
//  instructionTid_o      out  TidSize             head TID
//  instructionMajId_o    out  instructionCounterWidth  head major ID
//  occupancy_o           out  queueIndexWidth+1   entries currently stored (excludes output register)
// BEHAVIOUR
//  Reset (reset_i=1 at edge)
//   - Queue empty, rd/wr pointers 0, count 0, major ID counter 0.
//   - enable_o and all data outputs 0.
//   - fetchReady_o = !reset_i && (count < queueDepth), combinational; 0 while reset_i high.
//  Push
//   - Occurs when fetchEnable_i && fetchReady_o && !flush_i.
//   - Writes {word, addr, pid, tid, majIdCounter} at wrPtr; wrPtr+1 (wraps mod queueDepth); majIdCounter+1 (wraps at 2^width).
//   - fetchEnable_i while !fetchReady_o: word dropped, counter unchanged.
//   - When full, fetchReady_o=0 even if a pop occurs the same cycle (no same-cycle push-on-full).
//  Pop / output (output register stage)
//   - stall_i=1: enable_o and all data outputs hold; no pop.
//   - stall_i=0, count>0: head entry loaded into outputs, enable_o=1, rdPtr+1 (wraps).
//   - stall_i=0, count=0: enable_o=0, data outputs hold last values.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//  Latency
//   - Word pushed at edge N into an empty queue with no stall appears with enable_o=1 after edge N+1.
//   - Sustained throughput is 1 per cycle.
//  Flush (flush_i=1 at edge; priority over push, pop and stall)
//   - Pointers and count cleared; enable_o=0; data outputs hold.
//   - Same-cycle push is discarded.
//   - majIdCounter is NOT reset, so IDs stay unique.
//  Ordering
//   - Strict FIFO.
//   - Major IDs on enable_o=1 cycles are strictly increasing (mod 2^width), with gaps only across flushes.
//  Reset mid-operation: same as reset; queued entries lost, counter returns to 0.
// TESTING
//  1. Reset, then push 0x48000000 @addr 0x100, no stall -> cycle+2: enable_o=1, instruction_o=0x48000000, majId=0; next cycle enable_o=0.
//  2. stall_i=1, push 5 words back-to-back -> 4 accepted (occupancy_o=4, fetchReady_o=0), 5th dropped; release stall -> majIds 0,1,2,3 on consecutive cycles.
//  3. stall_i held 3 cycles with enable_o=1 -> all outputs stable those cycles; resumes next entry when stall drops.
//  4. 2 entries queued, flush_i together with a push -> next cycle enable_o=0, occupancy_o=0; following push gets majId 3 (counter not reset).
//  5. Preload counter near 2^64-1 via forced value, push 2 -> majIds 0xFFFF_FFFF_FFFF_FFFF then 0; wrPtr wraps after 4 pushes with data intact.
//  6. Continuous push every cycle, stall_i=0 -> enable_o=1 every cycle after initial 2-cycle latency, occupancy_o stays <=1, order preserved.

Source files
------------

// File: rtl/fetch_decode_queue_if.sv
// Purpose : fetch-to-decode bundle: fetch push side, flush/stall controls, decode output side.
// Latency : none; wires only.
// Backpres: fetchReady_o gates the push side; stall_i holds the decode side.
// Ports   : master = fetch/decode environment, slave = fetch_decode_queue.
interface fetch_decode_queue_if #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int queueIndexWidth         = 2
);
   // fetch side
   logic                               fetchEnable_i;
   logic [0:instructionWidth-1]        fetchInstruction_i;   // bit 0 is the MSB
   logic [addressWidth-1:0]            fetchAddress_i;
   logic [PidSize-1:0]                 fetchPid_i;
   logic [TidSize-1:0]                 fetchTid_i;
   logic                               fetchReady_o;
   // pipeline control
   logic                               flush_i;
   logic                               stall_i;
   // decode side
   logic                               enable_o;
   logic [0:instructionWidth-1]        instruction_o;
   logic [addressWidth-1:0]            instructionAddress_o;
   logic [PidSize-1:0]                 instructionPid_o;
   logic [TidSize-1:0]                 instructionTid_o;
   logic [instructionCounterWidth-1:0] instructionMajId_o;
   logic [queueIndexWidth:0]           occupancy_o;

   modport master (
      output fetchEnable_i, fetchInstruction_i, fetchAddress_i, fetchPid_i, fetchTid_i,
      output flush_i, stall_i,
      input  fetchReady_o, enable_o, instruction_o, instructionAddress_o,
      input  instructionPid_o, instructionTid_o, instructionMajId_o, occupancy_o
   );

   modport slave (
      input  fetchEnable_i, fetchInstruction_i, fetchAddress_i, fetchPid_i, fetchTid_i,
      input  flush_i, stall_i,
      output fetchReady_o, enable_o, instruction_o, instructionAddress_o,
      output instructionPid_o, instructionTid_o, instructionMajId_o, occupancy_o
   );
endinterface

// File: rtl/fetch_decode_queue.sv
// Purpose : instruction queue between fetch and decode format scan; stamps each accepted word with a major ID.
// Latency : a word pushed at edge N into an empty, unstalled queue is presented (enable_o=1) after edge N+1.
// Backpres: fetchReady_o drops when every entry is occupied (no push-on-full); stall_i freezes the output register.
// Ports   : clock_i, reset_i (synchronous, active-high) and bus (slave modport): fetch push side with
//           fetchReady_o, flush_i/stall_i controls, registered decode bundle and occupancy_o.
module fetch_decode_queue #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int queueDepth              = 4,
   parameter int queueIndexWidth         = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   fetch_decode_queue_if.slave  bus
);

   typedef struct packed {
      logic [0:instructionWidth-1]        word;
      logic [addressWidth-1:0]            addr;
      logic [PidSize-1:0]                 pid;
      logic [TidSize-1:0]                 tid;
      logic [instructionCounterWidth-1:0] maj_id;
   } entry_t;

   localparam logic [queueIndexWidth:0] DEPTH = (queueIndexWidth+1)'(queueDepth);

   entry_t                             mem_q [queueDepth];
   entry_t                             mem_d [queueDepth];
   logic [queueIndexWidth-1:0]         wr_ptr_q, wr_ptr_d;
   logic [queueIndexWidth-1:0]         rd_ptr_q, rd_ptr_d;
   logic [queueIndexWidth:0]           count_q, count_d;
   logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
   logic                               enable_q, enable_d;
   entry_t                             out_q, out_d;

   logic fetch_ready;
   logic push;
   logic pop;

   always_comb begin
      // Readiness looks only at the stored count, so a full queue refuses a push even when it pops.
      fetch_ready = !reset_i && (count_q < DEPTH);
      push        = bus.fetchEnable_i && fetch_ready && !bus.flush_i;
      pop         = !bus.flush_i && !bus.stall_i && (count_q != '0);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      maj_id_d = maj_id_q;
      enable_d = enable_q;
      out_d    = out_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{word:   bus.fetchInstruction_i,
                             addr:   bus.fetchAddress_i,
                             pid:    bus.fetchPid_i,
                             tid:    bus.fetchTid_i,
                             maj_id: maj_id_q};
         wr_ptr_d = wr_ptr_q + queueIndexWidth'(1);
         maj_id_d = maj_id_q + instructionCounterWidth'(1);
      end

      // Without a stall the output register either takes the head or goes idle with data held.
      if (!bus.stall_i) begin
         enable_d = pop;
      end
      if (pop) begin
         out_d    = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + queueIndexWidth'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + (queueIndexWidth+1)'(1);
         2'b01:   count_d = count_q - (queueIndexWidth+1)'(1);
         default: count_d = count_q;
      endcase

      // Flush wins over everything, but leaves data outputs and the ID counter alone so IDs stay unique.
      if (bus.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         enable_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < queueDepth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         maj_id_q <= '0;
         enable_q <= 1'b0;
         out_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         maj_id_q <= maj_id_d;
         enable_q <= enable_d;
         out_q    <= out_d;
      end
   end

   assign bus.fetchReady_o         = fetch_ready;
   assign bus.enable_o             = enable_q;
   assign bus.instruction_o        = out_q.word;
   assign bus.instructionAddress_o = out_q.addr;
   assign bus.instructionPid_o     = out_q.pid;
   assign bus.instructionTid_o     = out_q.tid;
   assign bus.instructionMajId_o   = out_q.maj_id;
   assign bus.occupancy_o          = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Purpose : scoreboard bench for fetch_decode_queue; stimulus pushes expected bundles, a monitor pops and compares.
// Latency : expects a pushed word on the outputs two sampling points after it is driven.
// Backpres: exercises full-queue drop, stall hold, flush and reset.
module tb_fetch_decode_queue;
   localparam int AW  = 64;
   localparam int IW  = 32;
   localparam int PW  = 20;
   localparam int TW  = 16;
   localparam int CW  = 64;
   localparam int QD  = 4;
   localparam int QIW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_decode_queue_if #(
      .addressWidth(AW), .instructionWidth(IW), .PidSize(PW), .TidSize(TW),
      .instructionCounterWidth(CW), .queueIndexWidth(QIW)
   ) bus ();

   fetch_decode_queue #(
      .addressWidth(AW), .instructionWidth(IW), .PidSize(PW), .TidSize(TW),
      .instructionCounterWidth(CW), .queueDepth(QD), .queueIndexWidth(QIW)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] word;
      logic [63:0] addr;
      logic [19:0] pid;
      logic [15:0] tid;
      logic [63:0] maj;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic rst_seen   = 1'b1;
   logic flush_seen = 1'b0;
   logic stall_seen = 1'b0;
   always @(posedge clk) begin
      rst_seen   <= rst;
      flush_seen <= bus.flush_i;
      stall_seen <= bus.stall_i;
   end

   logic        prev_en   = 1'b0;
   logic [31:0] prev_word = '0;
   logic [63:0] prev_addr = '0;
   logic [63:0] prev_maj  = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (rst_seen || flush_seen) begin
         chk("enable_after_reset_or_flush", 64'(bus.enable_o), 64'd0);
      end else if (stall_seen) begin
         chk("stall_hold_enable", 64'(bus.enable_o), 64'(prev_en));
         chk("stall_hold_word", 64'(bus.instruction_o), 64'(prev_word));
         chk("stall_hold_addr", bus.instructionAddress_o, prev_addr);
         chk("stall_hold_majid", bus.instructionMajId_o, prev_maj);
      end else if (bus.enable_o) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got majid 0x%0h expected no output at %0t",
                     bus.instructionMajId_o, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("out_word", 64'(bus.instruction_o), 64'(mon_e.word));
            chk("out_addr", bus.instructionAddress_o, mon_e.addr);
            chk("out_pid", 64'(bus.instructionPid_o), 64'(mon_e.pid));
            chk("out_tid", 64'(bus.instructionTid_o), 64'(mon_e.tid));
            chk("out_majid", bus.instructionMajId_o, mon_e.maj);
         end
      end
      prev_en   = bus.enable_o;
      prev_word = bus.instruction_o;
      prev_addr = bus.instructionAddress_o;
      prev_maj  = bus.instructionMajId_o;
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [31:0] w, input logic [63:0] a, input logic [19:0] p, input logic [15:0] t);
      bus.fetchEnable_i      = 1'b1;
      bus.fetchInstruction_i = w;
      bus.fetchAddress_i     = a;
      bus.fetchPid_i         = p;
      bus.fetchTid_i         = t;
   endtask

   task automatic push_exp(input logic [31:0] w, input logic [63:0] a, input logic [19:0] p,
                           input logic [15:0] t, input logic [63:0] m);
      exp_t e;
      drive(w, a, p, t);
      e.word = w; e.addr = a; e.pid = p; e.tid = t; e.maj = m;
      sb.push_back(e);
   endtask

   task automatic idle();
      bus.fetchEnable_i = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      idle();
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      @(posedge clk);
      sb.delete();
      @(negedge clk);
      chk("reset_enable", 64'(bus.enable_o), 64'd0);
      chk("reset_word", 64'(bus.instruction_o), 64'd0);
      chk("reset_majid", bus.instructionMajId_o, 64'd0);
      chk("reset_occupancy", 64'(bus.occupancy_o), 64'd0);
      chk("reset_fetch_ready_low", 64'(bus.fetchReady_o), 64'd0);
      rst = 1'b0;
      #1;
      chk("fetch_ready_after_reset", 64'(bus.fetchReady_o), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus.fetchEnable_i      = 1'b0;
      bus.fetchInstruction_i = '0;
      bus.fetchAddress_i     = '0;
      bus.fetchPid_i         = '0;
      bus.fetchTid_i         = '0;
      bus.flush_i            = 1'b0;
      bus.stall_i            = 1'b0;
      do_reset();

      // 1: single word, two-cycle latency, one-cycle enable, data held afterwards
      push_exp(32'h4800_0000, 64'h100, 20'h5, 16'h7, 64'd0);
      @(negedge clk);
      idle();
      chk("t1_occupancy", 64'(bus.occupancy_o), 64'd1);
      chk("t1_enable_not_yet", 64'(bus.enable_o), 64'd0);
      @(negedge clk);
      chk("t1_enable_first", 64'(bus.enable_o), 64'd1);
      @(negedge clk);
      chk("t1_enable_drop", 64'(bus.enable_o), 64'd0);
      chk("t1_word_hold", 64'(bus.instruction_o), 64'h4800_0000);

      // 2: fill while stalled, fifth word dropped, drain IDs 0..3 back to back
      do_reset();
      bus.stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            chk("t2_full_occupancy", 64'(bus.occupancy_o), 64'd4);
            chk("t2_full_not_ready", 64'(bus.fetchReady_o), 64'd0);
            drive(32'h2000_00FF, 64'h2FF0, 20'hFF, 16'hFF);
         end else begin
            push_exp(32'h2000_0000 + 32'(i), 64'h2000 + 64'(4 * i), 20'(i + 1), 16'(i + 2), 64'(i));
         end
         @(negedge clk);
      end
      idle();
      chk("t2_occupancy_after_drop", 64'(bus.occupancy_o), 64'd4);
      bus.stall_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_drain_enable", 64'(bus.enable_o), 64'd1);
      end
      @(negedge clk);
      chk("t2_drained_enable", 64'(bus.enable_o), 64'd0);
      chk("t2_drained_occupancy", 64'(bus.occupancy_o), 64'd0);

      // 3: stall held three cycles while presenting, then resume
      push_exp(32'h3000_0001, 64'h3004, 20'h31, 16'h31, 64'd4);
      @(negedge clk);
      push_exp(32'h3000_0002, 64'h3008, 20'h32, 16'h32, 64'd5);
      @(negedge clk);
      idle();
      bus.stall_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_stall_enable", 64'(bus.enable_o), 64'd1);
         chk("t3_stall_majid", bus.instructionMajId_o, 64'd4);
      end
      chk("t3_occupancy", 64'(bus.occupancy_o), 64'd1);
      bus.stall_i = 1'b0;
      @(negedge clk);
      chk("t3_resume_majid", bus.instructionMajId_o, 64'd5);
      @(negedge clk);

      // 4: flush with two queued, a presented word and a same-cycle push
      push_exp(32'h4000_0001, 64'h4004, 20'h41, 16'h41, 64'd6);
      @(negedge clk);
      drive(32'h4000_0002, 64'h4008, 20'h42, 16'h42);
      @(negedge clk);
      drive(32'h4000_0003, 64'h400C, 20'h43, 16'h43);
      bus.stall_i = 1'b1;
      @(negedge clk);
      chk("t4_occupancy_before_flush", 64'(bus.occupancy_o), 64'd2);
      chk("t4_enable_before_flush", 64'(bus.enable_o), 64'd1);
      bus.flush_i = 1'b1;
      drive(32'h4000_0004, 64'h4010, 20'h44, 16'h44);
      @(posedge clk);
      sb.delete();
      @(negedge clk);
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;
      idle();
      chk("t4_flush_enable", 64'(bus.enable_o), 64'd0);
      chk("t4_flush_occupancy", 64'(bus.occupancy_o), 64'd0);
      chk("t4_flush_word_hold", 64'(bus.instruction_o), 64'h4000_0001);
      push_exp(32'h4000_0005, 64'h4014, 20'h45, 16'h45, 64'd9);
      @(negedge clk);
      idle();
      cyc(3);

      // 5: counter wrap from all-ones, write pointer wrap across five pushes
      force dut.maj_id_d = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      release dut.maj_id_d;
      for (int i = 0; i < 5; i++) begin
         push_exp(32'h5000_0000 + 32'(i), 64'h5000 + 64'(4 * i), 20'(i + 16), 16'(i + 32),
                  64'hFFFF_FFFF_FFFF_FFFF + 64'(i));
         @(negedge clk);
      end
      idle();
      cyc(3);
      chk("t5_occupancy_drained", 64'(bus.occupancy_o), 64'd0);

      // 6: continuous push, one per cycle
      for (int i = 0; i < 8; i++) begin
         push_exp(32'h6000_0000 + 32'(i), 64'h6000 + 64'(4 * i), 20'(i + 64), 16'(i + 96), 64'(4 + i));
         @(negedge clk);
         chk("t6_occupancy", 64'(bus.occupancy_o), 64'd1);
         if (i > 0) chk("t6_enable_streaming", 64'(bus.enable_o), 64'd1);
      end
      idle();
      cyc(3);

      // reset mid-operation: queued words lost, IDs restart at 0
      bus.stall_i = 1'b1;
      drive(32'h7000_0001, 64'h7004, 20'h71, 16'h71);
      @(negedge clk);
      drive(32'h7000_0002, 64'h7008, 20'h72, 16'h72);
      @(negedge clk);
      do_reset();
      push_exp(32'h7000_0003, 64'h700C, 20'h73, 16'h73, 64'd0);
      @(negedge clk);
      idle();
      cyc(4);

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
